cc_goal_status_tracker: RTL and testbench
=========================================

Name: cc_goal_status_tracker

Overview:
- Sequential successor to the combinational last-row win comparator in the Frogger datapath.
- Each frame tick it evaluates the frog row against the obstacle row and the goal row, and tracks the following as registered state: filled goal slots, lives, hit/respawn timing and level progression.
- Drives a registered 2-bit game status to the top-level FSM and display; width and goal layout are parametrised.

Parameters:
- DATAWIDTH, 8, columns per row.
- GOAL_MASK, 8'b01010101 (DATAWIDTH bits), columns that are valid goal slots; must be nonzero.
- LIVES_INIT, 3, lives loaded at reset/new game; 1..2^LIVES_W-1.
- LIVES_W, 2, lives counter width.
- HIT_HOLD, 4, frame ticks spent in HIT before respawn; >=1.
- LEVEL_W, 4, level counter width.

Ports:
- CC_GOALTRACKER_CLOCK_50 in 1: system clock, single clock domain.
- CC_GOALTRACKER_RESET_InHigh in 1: reset, synchronous, active-high.
- CC_GOALTRACKER_tick_In in 1: frame strobe, one clock wide; all evaluation happens only on it.
- CC_GOALTRACKER_frogRow_InBUS in DATAWIDTH: one-hot frog column in its current row; all-zero means no frog.
- CC_GOALTRACKER_obstacleRow_InBUS in DATAWIDTH: obstacle occupancy of the frog's current row.
- CC_GOALTRACKER_atGoal_In in 1: frog is on the last (goal) row.
- CC_GOALTRACKER_restart_In in 1: request a next level or a new game.
- CC_GOALTRACKER_status_OutBUS out 2: 00 PLAY, 01 HIT, 10 LEVEL_WIN, 11 GAME_OVER.
- CC_GOALTRACKER_goals_OutBUS out DATAWIDTH: filled goal slots.
- CC_GOALTRACKER_lives_OutBUS out LIVES_W: remaining lives.
- CC_GOALTRACKER_level_OutBUS out LEVEL_W: current level.
- CC_GOALTRACKER_respawn_Out out 1: one-clock pulse commanding the frog to return to its start.

Behaviour:
- Reset (sync, highest priority, takes effect at the next edge from any state): state PLAY; status 00; goals 0; lives LIVES_INIT; level 0; respawn 0; hold counter 0.
- All outputs are registered. Status reflects an event on the clock edge after the tick.
- PLAY, on tick. Priority order, first match wins:
  - (a) collision = |(frog & obstacle) -> HIT.
  - (b) atGoal and frog & GOAL_MASK == 0 (non-slot column) -> HIT.
  - (c) atGoal and frog & goals != 0 (slot already filled) -> HIT.
  - (d) atGoal with a valid empty slot -> goals |= frog; respawn pulses. If new goals == GOAL_MASK -> LEVEL_WIN, otherwise stay in PLAY.
  - (e) otherwise no change.
- Frog all-zero on a tick: no event, even when atGoal is high.
- HIT entry: lives decrements; hold counter loads HIT_HOLD.
  - If lives was 1 (becomes 0) -> GAME_OVER directly with no respawn; status 11.
  - Otherwise, while in HIT, the counter decrements on each tick. At 0 -> PLAY, respawn pulses one clock, status 00.
  - Further collisions during HIT are ignored.
- LEVEL_WIN: holds until restart (level-sensitive, sampled on any clock). On restart: goals cleared; level increments, saturating at 2^LEVEL_W-1; lives unchanged; respawn pulses; state -> PLAY.
- GAME_OVER: holds until restart. On restart: goals 0, lives LIVES_INIT, level 0, respawn pulses, state -> PLAY.
- Restart is ignored in PLAY and HIT.
- Simultaneous events:
  - restart and tick in the same cycle in LEVEL_WIN/GAME_OVER: restart is handled, the tick is discarded.
  - reset overrides everything.
- Multi-hot frog input is illegal. The collision check still uses the full AND; the goal rule treats any overlap with goals as occupied.

Optional Feature:
- Macro CC_GOALTRACKER_SCORE_EN.
- Defined:
  - adds output CC_GOALTRACKER_score_OutBUS [15:0];
  - +10 per goal filled, +50 extra on LEVEL_WIN entry;
  - saturates at 16'hFFFF;
  - cleared by reset and by restart from GAME_OVER; kept on level restart.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package cc_goaltracker_pkg:
  - state enum/localparams PLAY=2'b00, HIT=2'b01, LEVEL_WIN=2'b10, GAME_OVER=2'b11 (state encoding equals the status encoding);
  - score increments 10/50;
  - score width 16.
- Sub-module cc_goaltracker_slot_check (combinational): computes collision, bad_slot, occupied and all_filled from the frog, obstacle, goals and GOAL_MASK.
- Top level holds the FSM, the lives/hold/level counters and the goal register.

Test Plan:
- Reset then tick with frog 8'b00000100, obstacle 8'b00000100 -> next clock status 01, lives 2. After 4 ticks -> status 00, respawn pulse of 1 clock.
- With atGoal: fill slots 8'b00000001, 8'b00000100, 8'b00010000, 8'b01000000 on separate ticks -> goals 8'b01010101, status 10. Restart -> level 1, goals 0, status 00.
- atGoal with frog 8'b00000010 (non-slot) -> HIT. Refill of an already-filled slot 8'b00000001 -> HIT; goals unchanged.
- Three collisions, each waiting out HIT -> third goes straight to status 11, lives 0, no respawn. Restart -> lives 3, level 0.
- Collision and a valid goal on the same tick -> HIT wins, goals unchanged. Reset asserted mid-HIT -> next clock status 00, lives 3.
- CC_GOALTRACKER_SCORE_EN defined: fill all 4 slots -> score 90. Level restart keeps 90. GAME_OVER restart clears it to 0.

Source files
------------

// File: rtl/cc_goaltracker_pkg.sv
// cc_goaltracker_pkg: shared state/status encoding and score constants
package cc_goaltracker_pkg;
    typedef enum logic [1:0] {
        PLAY      = 2'b00,
        HIT       = 2'b01,
        LEVEL_WIN = 2'b10,
        GAME_OVER = 2'b11
    } state_e;
    localparam int SCORE_W    = 16;
    localparam int SCORE_GOAL = 10;
    localparam int SCORE_WIN  = 50;
endpackage

// File: rtl/cc_goaltracker_slot_check.sv
// cc_goaltracker_slot_check: combinational row/goal classification for the frog
// Ports: frog_i (one-hot column), obstacle_i (row occupancy), goals_i (filled slots);
//        collision_o, bad_slot_o (not a goal column), occupied_o (slot already filled),
//        all_filled_o (filling this column completes GOAL_MASK)
module cc_goaltracker_slot_check #(
    parameter int                   DATAWIDTH = 8,
    parameter logic [DATAWIDTH-1:0] GOAL_MASK = 8'b01010101
) (
    input  logic [DATAWIDTH-1:0] frog_i,
    input  logic [DATAWIDTH-1:0] obstacle_i,
    input  logic [DATAWIDTH-1:0] goals_i,
    output logic                 collision_o,
    output logic                 bad_slot_o,
    output logic                 occupied_o,
    output logic                 all_filled_o
);
    assign collision_o  = |(frog_i & obstacle_i);
    assign bad_slot_o   = (frog_i & GOAL_MASK) == '0;
    assign occupied_o   = |(frog_i & goals_i);
    assign all_filled_o = (goals_i | frog_i) == GOAL_MASK;
endmodule

// File: rtl/cc_goal_status_tracker.sv
// cc_goal_status_tracker: per-frame goal/lives/level tracker driving registered game status
// Ports: clock, sync active-high reset, frame tick, frog/obstacle rows, atGoal, restart;
//        status (00 PLAY, 01 HIT, 10 LEVEL_WIN, 11 GAME_OVER), goals, lives, level, respawn pulse.
// Optional: CC_GOALTRACKER_SCORE_EN adds a saturating 16-bit score output.
module cc_goal_status_tracker
    import cc_goaltracker_pkg::*;
#(
    parameter int                   DATAWIDTH  = 8,
    parameter logic [DATAWIDTH-1:0] GOAL_MASK  = 8'b01010101,
    parameter int                   LIVES_INIT = 3,
    parameter int                   LIVES_W    = 2,
    parameter int                   HIT_HOLD   = 4,
    parameter int                   LEVEL_W    = 4
) (
    input  logic                 CC_GOALTRACKER_CLOCK_50,
    input  logic                 CC_GOALTRACKER_RESET_InHigh,
    input  logic                 CC_GOALTRACKER_tick_In,
    input  logic [DATAWIDTH-1:0] CC_GOALTRACKER_frogRow_InBUS,
    input  logic [DATAWIDTH-1:0] CC_GOALTRACKER_obstacleRow_InBUS,
    input  logic                 CC_GOALTRACKER_atGoal_In,
    input  logic                 CC_GOALTRACKER_restart_In,
    output logic [1:0]           CC_GOALTRACKER_status_OutBUS,
    output logic [DATAWIDTH-1:0] CC_GOALTRACKER_goals_OutBUS,
    output logic [LIVES_W-1:0]   CC_GOALTRACKER_lives_OutBUS,
    output logic [LEVEL_W-1:0]   CC_GOALTRACKER_level_OutBUS,
`ifdef CC_GOALTRACKER_SCORE_EN
    output logic [SCORE_W-1:0]   CC_GOALTRACKER_score_OutBUS,
`endif
    output logic                 CC_GOALTRACKER_respawn_Out
);
    localparam int HOLD_W = $clog2(HIT_HOLD + 1);

    state_e               state_q, state_d;
    logic [DATAWIDTH-1:0] goals_q, goals_d;
    logic [LIVES_W-1:0]   lives_q, lives_d;
    logic [LEVEL_W-1:0]   level_q, level_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic                 respawn_q, respawn_d;
    logic                 collision, bad_slot, occupied, all_filled, play_tick, goal_try, hit, fill;

    wire clk = CC_GOALTRACKER_CLOCK_50;
    wire rst = CC_GOALTRACKER_RESET_InHigh;

    cc_goaltracker_slot_check #(
        .DATAWIDTH (DATAWIDTH),
        .GOAL_MASK (GOAL_MASK)
    ) u_slot_check (
        .frog_i       (CC_GOALTRACKER_frogRow_InBUS),
        .obstacle_i   (CC_GOALTRACKER_obstacleRow_InBUS),
        .goals_i      (goals_q),
        .collision_o  (collision),
        .bad_slot_o   (bad_slot),
        .occupied_o   (occupied),
        .all_filled_o (all_filled)
    );

    // An empty frog row never counts as a goal attempt, even on the goal row.
    assign play_tick = state_q == PLAY && CC_GOALTRACKER_tick_In;
    assign goal_try  = CC_GOALTRACKER_atGoal_In && |CC_GOALTRACKER_frogRow_InBUS;
    assign hit       = play_tick && (collision || (goal_try && (bad_slot || occupied)));
    assign fill      = play_tick && !hit && goal_try;

    always_comb begin
        state_d   = state_q;
        goals_d   = goals_q;
        lives_d   = lives_q;
        level_d   = level_q;
        hold_d    = hold_q;
        respawn_d = 1'b0;
        case (state_q)
            PLAY: begin
                if (hit) begin
                    lives_d = lives_q - 1'b1;
                    hold_d  = HOLD_W'(HIT_HOLD);
                    state_d = lives_q == LIVES_W'(1) ? GAME_OVER : HIT;
                end else if (fill) begin
                    goals_d   = goals_q | CC_GOALTRACKER_frogRow_InBUS;
                    respawn_d = 1'b1;
                    state_d   = all_filled ? LEVEL_WIN : PLAY;
                end
            end
            HIT: begin
                if (CC_GOALTRACKER_tick_In) begin
                    hold_d = hold_q <= HOLD_W'(1) ? '0 : hold_q - 1'b1;
                    if (hold_q <= HOLD_W'(1)) begin
                        state_d   = PLAY;
                        respawn_d = 1'b1;
                    end
                end
            end
            LEVEL_WIN: begin
                if (CC_GOALTRACKER_restart_In) begin
                    goals_d   = '0;
                    level_d   = &level_q ? level_q : level_q + 1'b1;
                    respawn_d = 1'b1;
                    state_d   = PLAY;
                end
            end
            GAME_OVER: begin
                if (CC_GOALTRACKER_restart_In) begin
                    goals_d   = '0;
                    lives_d   = LIVES_W'(LIVES_INIT);
                    level_d   = '0;
                    respawn_d = 1'b1;
                    state_d   = PLAY;
                end
            end
            default: state_d = PLAY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= PLAY;
            goals_q   <= '0;
            lives_q   <= LIVES_W'(LIVES_INIT);
            level_q   <= '0;
            hold_q    <= '0;
            respawn_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            goals_q   <= goals_d;
            lives_q   <= lives_d;
            level_q   <= level_d;
            hold_q    <= hold_d;
            respawn_q <= respawn_d;
        end
    end

    assign CC_GOALTRACKER_status_OutBUS = state_q;
    assign CC_GOALTRACKER_goals_OutBUS  = goals_q;
    assign CC_GOALTRACKER_lives_OutBUS  = lives_q;
    assign CC_GOALTRACKER_level_OutBUS  = level_q;
    assign CC_GOALTRACKER_respawn_Out   = respawn_q;

`ifdef CC_GOALTRACKER_SCORE_EN
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W:0]   score_sum;

    // One extra carry bit detects overflow so the score clamps at all-ones.
    always_comb begin
        score_sum = {1'b0, score_q} + (SCORE_W+1)'(fill ? (all_filled ? SCORE_GOAL + SCORE_WIN : SCORE_GOAL) : 0);
        score_d   = (state_q == GAME_OVER && CC_GOALTRACKER_restart_In) ? '0 :
                    score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) score_q <= '0;
        else     score_q <= score_d;
    end

    assign CC_GOALTRACKER_score_OutBUS = score_q;
`endif
endmodule

// File: tb/tb_cc_goal_status_tracker.sv
// tb_cc_goal_status_tracker: directed scoreboard bench for cc_goal_status_tracker
module tb_cc_goal_status_tracker;
    localparam logic [1:0] P = 2'b00, H = 2'b01, W = 2'b10, G = 2'b11;

    typedef struct {
        logic [1:0]  st;
        logic [7:0]  gl;
        logic [1:0]  lv;
        logic [3:0]  lev;
        logic        rp;
        logic [15:0] sc;
        string       nm;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic [7:0] frog = '0;
    logic [7:0] obst = '0;
    logic       at_goal = 1'b0;
    logic       restart = 1'b0;
    logic [1:0] status;
    logic [7:0] goals;
    logic [1:0] lives;
    logic [3:0] level;
    logic       respawn;
    logic [15:0] score;

    exp_t exp_q[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cc_goal_status_tracker dut (
        .CC_GOALTRACKER_CLOCK_50          (clk),
        .CC_GOALTRACKER_RESET_InHigh      (rst),
        .CC_GOALTRACKER_tick_In           (tick),
        .CC_GOALTRACKER_frogRow_InBUS     (frog),
        .CC_GOALTRACKER_obstacleRow_InBUS (obst),
        .CC_GOALTRACKER_atGoal_In         (at_goal),
        .CC_GOALTRACKER_restart_In        (restart),
        .CC_GOALTRACKER_status_OutBUS     (status),
        .CC_GOALTRACKER_goals_OutBUS      (goals),
        .CC_GOALTRACKER_lives_OutBUS      (lives),
        .CC_GOALTRACKER_level_OutBUS      (level),
`ifdef CC_GOALTRACKER_SCORE_EN
        .CC_GOALTRACKER_score_OutBUS      (score),
`endif
        .CC_GOALTRACKER_respawn_Out       (respawn)
    );

`ifndef CC_GOALTRACKER_SCORE_EN
    assign score = '0;
`endif

    // Drive one cycle of inputs and queue what the outputs must be after the next edge.
    task automatic step(input logic r, input logic tk, input logic [7:0] fr, input logic [7:0] ob,
                        input logic ag, input logic rs, input logic [1:0] st, input logic [7:0] gl,
                        input logic [1:0] lv, input logic [3:0] lev, input logic rp, input int sc,
                        input string nm);
        exp_t e;
        @(negedge clk);
        rst = r; tick = tk; frog = fr; obst = ob; at_goal = ag; restart = rs;
        e.st = st; e.gl = gl; e.lv = lv; e.lev = lev; e.rp = rp; e.sc = 16'(sc); e.nm = nm;
        exp_q.push_back(e);
    endtask

    // Four ticks in HIT (with collisions that must be ignored), then respawn and a quiet cycle.
    task automatic hold_out(input logic [7:0] gl, input logic [1:0] lv, input logic [3:0] lev, input int sc);
        for (int i = 0; i < 3; i++) step(0, 1, 8'h04, 8'h04, 0, 0, H, gl, lv, lev, 0, sc, "hit_hold");
        step(0, 1, 8'h04, 8'h04, 0, 0, P, gl, lv, lev, 1, sc, "hit_respawn");
        step(0, 0, 8'h00, 8'h00, 0, 0, P, gl, lv, lev, 0, sc, "respawn_one_clk");
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            checks++;
            if ({status, goals, lives, level, respawn} !== {cur.st, cur.gl, cur.lv, cur.lev, cur.rp}) begin
                errors++;
                $display("FAIL %s: got st=%b goals=%b lives=%0d level=%0d respawn=%b, want st=%b goals=%b lives=%0d level=%0d respawn=%b",
                         cur.nm, status, goals, lives, level, respawn, cur.st, cur.gl, cur.lv, cur.lev, cur.rp);
            end
`ifdef CC_GOALTRACKER_SCORE_EN
            checks++;
            if (score !== cur.sc) begin
                errors++;
                $display("FAIL %s_score: got %0d, want %0d", cur.nm, score, cur.sc);
            end
`endif
        end
    end

    initial begin
        step(1, 0, 8'h00, 8'h00, 0, 0, P, 8'h00, 3, 0, 0, 0, "reset");
        step(0, 1, 8'h04, 8'h04, 0, 0, H, 8'h00, 2, 0, 0, 0, "collision_hit");
        step(0, 0, 8'h00, 8'h00, 0, 1, H, 8'h00, 2, 0, 0, 0, "restart_ignored_hit");
        hold_out(8'h00, 2, 0, 0);
        step(0, 1, 8'h01, 8'h00, 1, 0, P, 8'h01, 2, 0, 1, 10, "fill_01");
        step(0, 1, 8'h04, 8'h00, 1, 0, P, 8'h05, 2, 0, 1, 20, "fill_04");
        step(0, 1, 8'h10, 8'h00, 1, 0, P, 8'h15, 2, 0, 1, 30, "fill_10");
        step(0, 1, 8'h40, 8'h00, 1, 0, W, 8'h55, 2, 0, 1, 90, "level_win");
        step(0, 1, 8'h01, 8'h00, 1, 0, W, 8'h55, 2, 0, 0, 90, "win_hold");
        step(0, 1, 8'h04, 8'h04, 0, 1, P, 8'h00, 2, 1, 1, 90, "level_restart");
        step(0, 0, 8'h00, 8'h00, 0, 0, P, 8'h00, 2, 1, 0, 90, "after_level_restart");
        step(0, 1, 8'h01, 8'h00, 1, 0, P, 8'h01, 2, 1, 1, 100, "fill_l1");
        step(0, 1, 8'h01, 8'h00, 1, 0, H, 8'h01, 1, 1, 0, 100, "refill_hit");
        hold_out(8'h01, 1, 1, 100);
        step(0, 1, 8'h02, 8'h00, 1, 0, G, 8'h01, 0, 1, 0, 100, "last_life_game_over");
        step(0, 1, 8'h00, 8'h00, 0, 0, G, 8'h01, 0, 1, 0, 100, "game_over_hold");
        step(0, 0, 8'h00, 8'h00, 0, 1, P, 8'h00, 3, 0, 1, 0, "game_over_restart");
        step(0, 1, 8'h00, 8'h00, 1, 0, P, 8'h00, 3, 0, 0, 0, "no_frog_at_goal");
        step(0, 0, 8'h00, 8'h00, 0, 1, P, 8'h00, 3, 0, 0, 0, "restart_ignored_play");
        step(0, 1, 8'h02, 8'h00, 1, 0, H, 8'h00, 2, 0, 0, 0, "nonslot_hit");
        hold_out(8'h00, 2, 0, 0);
        step(1, 0, 8'h00, 8'h00, 0, 0, P, 8'h00, 3, 0, 0, 0, "reset2");
        step(0, 1, 8'h80, 8'h80, 0, 0, H, 8'h00, 2, 0, 0, 0, "collision_1");
        hold_out(8'h00, 2, 0, 0);
        step(0, 1, 8'h08, 8'h0C, 0, 0, H, 8'h00, 1, 0, 0, 0, "collision_2");
        hold_out(8'h00, 1, 0, 0);
        step(0, 1, 8'h20, 8'hFF, 0, 0, G, 8'h00, 0, 0, 0, 0, "collision_3_game_over");
        step(0, 1, 8'h00, 8'h00, 0, 1, P, 8'h00, 3, 0, 1, 0, "restart_tick_discarded");
        step(0, 1, 8'h04, 8'h04, 1, 0, H, 8'h00, 2, 0, 0, 0, "collision_beats_goal");
        step(0, 1, 8'h00, 8'h00, 0, 0, H, 8'h00, 2, 0, 0, 0, "hit_tick");
        step(1, 1, 8'h00, 8'h00, 0, 0, P, 8'h00, 3, 0, 0, 0, "reset_mid_hit");
        step(0, 1, 8'h01, 8'h00, 1, 0, P, 8'h01, 3, 0, 1, 10, "fill_after_reset");
        step(0, 0, 8'h00, 8'h00, 0, 0, P, 8'h01, 3, 0, 0, 10, "final_idle");
        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
